// File: rtl/iomem_router_pkg.sv
// rtl/iomem_router_pkg.sv - shared types and constants for the iomem router
package iomem_router_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ERROR,
    RESP
  } state_t;

  localparam int          SLOT_W           = 8;
  localparam logic [7:0]  STATUS_SLOT      = 8'hFF;
  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/iomem_watchdog.sv
// rtl/iomem_watchdog.sv - loadable up-counter with clear, enable and terminal-count flag
module iomem_watchdog
  import iomem_router_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TC_VALUE = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Counter: clear has priority over load, load over increment.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Greater-or-equal keeps TIMEOUT = 1 from waiting for a wrap-around.
  assign tc = (count >= TC_VALUE);

endmodule

// File: rtl/iomem_router.sv
// rtl/iomem_router.sv - iomem page decoder/sequencer; optional status slot via IOMEM_ROUTER_ERRSTAT_EN
module iomem_router
  import iomem_router_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter logic [7:0]  BASE_PAGE  = 8'h03,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = DEFAULT_ERR_DATA
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     iomem_valid,
  output logic                     iomem_ready,
  input  logic [3:0]               iomem_wstrb,
  input  logic [31:0]              iomem_addr,
  input  logic [31:0]              iomem_wdata,
  output logic [31:0]              iomem_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  output logic [15:0]              s_addr,
  output logic [3:0]               s_wstrb,
  output logic [31:0]              s_wdata,
  input  logic [NUM_SLAVES*32-1:0] s_rdata
);

  state_t              state, next_state;
  logic [SLOT_W-1:0]   slot, sel;
  logic                in_page, mapped, accept;
  logic                go_access, go_resp_ok, go_error;
  logic                sel_ready, wd_tc;
  logic [31:0]         sel_rdata;
  logic [NUM_SLAVES-1:0] onehot;
`ifdef IOMEM_ROUTER_ERRSTAT_EN
  logic                status_hit, timeout_hit;
  logic [15:0]         err_count;
  logic [7:0]          last_err_slot;
  logic                sticky_timeout;
`endif

  assign slot    = iomem_addr[23:16];
  assign in_page = (iomem_addr[31:24] == BASE_PAGE);
  assign mapped  = (int'(slot) < NUM_SLAVES);
  assign accept  = (state == IDLE) && iomem_valid && !iomem_ready && in_page;

  // Decode the one-hot request and pick the selected slot's ready/data.
  always_comb begin
    onehot    = '0;
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      onehot[k] = (int'(slot) == k);
      if (s_valid[k]) begin
        sel_rdata = s_rdata[32*k +: 32];
        sel_ready = s_ready[k];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state and transition strobes.
  always_comb begin
    next_state = state;
    go_access  = 1'b0;
    go_resp_ok = 1'b0;
    go_error   = 1'b0;
`ifdef IOMEM_ROUTER_ERRSTAT_EN
    status_hit  = 1'b0;
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef IOMEM_ROUTER_ERRSTAT_EN
          if (slot == STATUS_SLOT) begin
            next_state = RESP;
            status_hit = 1'b1;
          end else if (mapped) begin
            next_state = ACCESS;
            go_access  = 1'b1;
          end else begin
            next_state = ERROR;
            go_error   = 1'b1;
          end
`else
          if (mapped) begin
            next_state = ACCESS;
            go_access  = 1'b1;
          end else begin
            next_state = ERROR;
            go_error   = 1'b1;
          end
`endif
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          next_state = RESP;
          go_resp_ok = 1'b1;
        end else if (wd_tc) begin
          next_state = ERROR;
          go_error   = 1'b1;
`ifdef IOMEM_ROUTER_ERRSTAT_EN
          timeout_hit = 1'b1;
`endif
        end
      end
      ERROR:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The accept cycle counts as the first waited cycle, so the counter is
  // loaded with 1 rather than cleared when the access starts.
  iomem_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (16)
  ) u_watchdog (
    .clk        (clk),
    .resetn     (resetn),
    .clear      ((state != ACCESS) && !go_access),
    .load       (go_access),
    .load_value (16'd1),
    .enable     (state == ACCESS),
    .tc         (wd_tc)
  );

  // Slot-side request registers and CPU-side response registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      s_valid     <= '0;
      s_addr      <= '0;
      s_wstrb     <= '0;
      s_wdata     <= '0;
      sel         <= '0;
    end else begin
      iomem_ready <= (state == RESP);
      if (accept) begin
        s_addr  <= iomem_addr[15:0];
        s_wstrb <= iomem_wstrb;
        s_wdata <= iomem_wdata;
        sel     <= slot;
      end
      if (go_access) s_valid <= onehot;
      else if (go_resp_ok || go_error) s_valid <= '0;
      if (go_resp_ok) iomem_rdata <= sel_rdata;
      else if (state == ERROR) iomem_rdata <= ERR_DATA;
`ifdef IOMEM_ROUTER_ERRSTAT_EN
      else if (status_hit)
        iomem_rdata <= (iomem_wstrb == 4'b0) ?
                       {err_count, last_err_slot, 7'b0, sticky_timeout} : 32'h0;
`endif
    end
  end

`ifdef IOMEM_ROUTER_ERRSTAT_EN
  // Error statistics: any write to the status slot clears everything.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_count      <= '0;
      last_err_slot  <= '0;
      sticky_timeout <= 1'b0;
    end else if (status_hit && (iomem_wstrb != 4'b0)) begin
      err_count      <= '0;
      last_err_slot  <= '0;
      sticky_timeout <= 1'b0;
    end else if (go_error) begin
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      last_err_slot <= timeout_hit ? sel : slot;
      if (timeout_hit) sticky_timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_iomem_router.sv
// tb/tb_iomem_router.sv - self-checking bench for iomem_router against a transaction-level model
module tb_iomem_router;

  localparam int          N    = 4;
  localparam int          T    = 16;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            iomem_valid = 1'b0;
  logic            iomem_ready;
  logic [3:0]      iomem_wstrb = '0;
  logic [31:0]     iomem_addr = '0;
  logic [31:0]     iomem_wdata = '0;
  logic [31:0]     iomem_rdata;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready = '0;
  logic [15:0]     s_addr;
  logic [3:0]      s_wstrb;
  logic [31:0]     s_wdata;
  logic [N*32-1:0] s_rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_err_count = '0;
  logic [7:0]  m_last_slot = '0;
  logic        m_sticky = 1'b0;

  always #5 clk = ~clk;

  iomem_router #(
    .NUM_SLAVES (N),
    .BASE_PAGE  (8'h03),
    .TIMEOUT    (T),
    .ERR_DATA   (ERRD)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_addr      (s_addr),
    .s_wstrb     (s_wstrb),
    .s_wdata     (s_wdata),
    .s_rdata     (s_rdata)
  );

  task automatic model_error(input logic [7:0] slot, input bit tmo);
    if (m_err_count != 16'hFFFF) m_err_count = m_err_count + 16'd1;
    m_last_slot = slot;
    if (tmo) m_sticky = 1'b1;
  endtask

  // One CPU transaction: the slots answer after `delay` cycles of seeing
  // s_valid, unselected slots assert random ready noise.
  task automatic run_access(input logic [31:0] addr, input logic [3:0] wstrb,
                            input logic [31:0] wdata, input int delay,
                            input logic [31:0] rd, input string name);
    logic [7:0]   slot;
    bit           in_page, exp_resp, chk_rdata, bad_sv;
    int           exp_lat, exp_acc, lat, acc, rdy_cnt;
    logic [31:0]  exp_rdata, got_rdata;
    logic [N-1:0] exp_sv;
    logic [31:0]  slot_data [N];
    slot      = addr[23:16];
    in_page   = (addr[31:24] == 8'h03);
    for (int k = 0; k < N; k++) slot_data[k] = $urandom();
    if (int'(slot) < N) slot_data[slot] = rd;
    for (int k = 0; k < N; k++) s_rdata[32*k +: 32] = slot_data[k];

    exp_resp  = in_page;
    chk_rdata = 1'b1;
    exp_lat   = 0;
    exp_acc   = 0;
    exp_sv    = '0;
    exp_rdata = '0;
    if (!in_page) begin
      chk_rdata = 1'b0;
`ifdef IOMEM_ROUTER_ERRSTAT_EN
    end else if (slot == 8'hFF) begin
      exp_lat = 2;
      if (wstrb == 4'b0) begin
        exp_rdata = {m_err_count, m_last_slot, 7'b0, m_sticky};
      end else begin
        chk_rdata   = 1'b0;
        m_err_count = '0;
        m_last_slot = '0;
        m_sticky    = 1'b0;
      end
`endif
    end else if (int'(slot) < N) begin
      exp_sv = N'(1) << slot;
      if (delay <= T - 2) begin
        exp_lat   = 3 + delay;
        exp_acc   = delay + 1;
        exp_rdata = rd;
      end else begin
        exp_lat   = T + 2;
        exp_acc   = T - 1;
        exp_rdata = ERRD;
        model_error(slot, 1'b1);
      end
    end else begin
      exp_lat   = 3;
      exp_rdata = ERRD;
      model_error(slot, 1'b0);
    end

    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = wstrb;
    iomem_wdata = wdata;
    lat = 0; acc = 0; rdy_cnt = 0; bad_sv = 1'b0; got_rdata = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (iomem_ready) begin
        rdy_cnt++;
        if (rdy_cnt == 1) begin
          lat       = n;
          got_rdata = iomem_rdata;
        end
      end
      if (s_valid != '0) begin
        acc++;
        if (s_valid !== exp_sv || s_addr !== addr[15:0] ||
            s_wstrb !== wstrb || s_wdata !== wdata) bad_sv = 1'b1;
      end
      s_ready = N'($urandom()) & ~s_valid;
      if (s_valid != '0 && (acc - 1) >= delay) s_ready = s_ready | s_valid;
      if (rdy_cnt > 0 && n == lat + 1) iomem_valid = 1'b0;
    end
    iomem_valid = 1'b0;
    s_ready     = '0;

    checks++;
    if (rdy_cnt !== (exp_resp ? 1 : 0)) begin
      errors++;
      $display("FAIL %s ready_pulses got %0d want %0d", name, rdy_cnt, exp_resp ? 1 : 0);
    end
    if (exp_resp) begin
      checks++;
      if (lat !== exp_lat) begin
        errors++;
        $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
      end
    end
    if (exp_resp && chk_rdata) begin
      checks++;
      if (got_rdata !== exp_rdata) begin
        errors++;
        $display("FAIL %s rdata got %08h want %08h", name, got_rdata, exp_rdata);
      end
    end
    checks++;
    if (acc !== exp_acc || bad_sv) begin
      errors++;
      $display("FAIL %s s_valid_cycles got %0d want %0d (bad_request=%0d)", name, acc, exp_acc, bad_sv);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({iomem_ready, s_valid, iomem_rdata, s_addr, s_wstrb, s_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%0b sv=%b rd=%08h a=%04h st=%h wd=%08h want all zero",
               iomem_ready, s_valid, iomem_rdata, s_addr, s_wstrb, s_wdata);
    end
    resetn = 1'b1;
  endtask

  task automatic test_directed();
    run_access(32'h0301_0004, 4'hF, 32'h1234_5678, 1, $urandom(), "write_slot1");
    run_access(32'h0302_0000, 4'h0, 32'h0, 5, 32'hCAFE_F00D, "read_slot2_wait5");
    run_access(32'h0300_0000, 4'h0, 32'h0, 1000, $urandom(), "timeout_slot0");
    run_access(32'h0307_0000, 4'h0, 32'h0, 0, $urandom(), "unmapped_slot7");
    run_access(32'h0400_0000, 4'h0, 32'h0, 0, $urandom(), "out_of_page");
  endtask

  task automatic test_timeout_boundary();
    run_access(32'h0301_0010, 4'h0, 32'h0, T - 2, $urandom(), "ready_at_timeout");
    run_access(32'h0301_0014, 4'h3, $urandom(), T - 1, $urandom(), "ready_after_timeout");
    run_access(32'h0303_0000, 4'h0, 32'h0, 0, $urandom(), "same_cycle_ready");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0303_00A0;
    iomem_wstrb = 4'h5;
    iomem_wdata = 32'hA5A5_5A5A;
    repeat (4) @(negedge clk);
    checks++;
    if (s_valid !== 4'b1000) begin
      errors++;
      $display("FAIL mid_reset_pre s_valid got %b want %b", s_valid, 4'b1000);
    end
    resetn      = 1'b0;
    iomem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_valid !== '0 || iomem_ready !== 1'b0 || s_addr !== '0 || s_wdata !== '0) begin
      errors++;
      $display("FAIL mid_reset got sv=%b rdy=%0b a=%04h wd=%08h want zero", s_valid, iomem_ready, s_addr, s_wdata);
    end
    resetn = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (30) begin
        @(negedge clk);
        if (iomem_ready || s_valid != '0) seen++;
      end
      checks++;
      if (seen !== 0) begin
        errors++;
        $display("FAIL mid_reset_quiet activity_cycles got %0d want 0", seen);
      end
    end
    run_access(32'h0303_0008, 4'h0, 32'h0, 2, $urandom(), "after_reset_slot3");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      logic [7:0]  page, slot;
      logic [3:0]  ws;
      int          d;
      page = ($urandom_range(0, 7) == 0) ? 8'h05 : 8'h03;
      slot = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
      ws   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      d    = $urandom_range(0, 20);
      run_access({page, slot, 16'($urandom())}, ws, $urandom(), d, $urandom(), "random");
    end
  endtask

`ifdef IOMEM_ROUTER_ERRSTAT_EN
  task automatic test_errstat();
    run_access(32'h03FF_0000, 4'hF, $urandom(), 0, 32'h0, "status_clear");
    run_access(32'h0300_0000, 4'h0, 32'h0, 1000, $urandom(), "status_tmo1");
    run_access(32'h0300_0000, 4'h0, 32'h0, 1000, $urandom(), "status_tmo2");
    run_access(32'h03FF_0000, 4'h0, 32'h0, 0, 32'h0, "status_read");
    run_access(32'h03FF_0000, 4'h1, 32'h1, 0, 32'h0, "status_write");
    run_access(32'h03FF_0000, 4'h0, 32'h0, 0, 32'h0, "status_read_zero");
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_timeout_boundary();
    test_reset_mid();
    test_back_to_back();
`ifdef IOMEM_ROUTER_ERRSTAT_EN
    test_errstat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
